// File: rtl/edge_detection.sv
// Streaming 8-bit horizontal-gradient edge detector with a scan-addressed frame buffer.
// Latency 1 cycle (write: edge value, read: buffer word); enb is the only stall, no output backpressure.
// Readout streams in linear address order; complete marks the last word presented.
module edge_detection #(
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int THRESH = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] modeCounter,
    input  logic       modeBuffer,
    input  logic       resetBuff,
    input  logic       enb,
    input  logic [7:0] In_Arrary,
    output logic [7:0] Edges,
    output logic       complete
);
    localparam int N  = IMG_W * IMG_H;
    localparam int AW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [7:0]    mem [N];
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [AW-1:0] ra;
    logic [7:0]    prev;
    logic          prev_vld;
    logic          full;
    logic          rdone;

    logic          hold;
    logic          colmajor;
    logic          line_start;
    logic          last_row;
    logic          last_col;
    logic          proc;
    logic          we;
    logic [7:0]    diff;
    logic [9:0]    tdiff;
    logic [7:0]    e;
    logic [AW-1:0] wa;

    always_comb begin
        hold       = (modeCounter == 3'b000);
        colmajor   = (modeCounter == 3'b010);
        line_start = colmajor ? (row == '0) : (col == '0);
        last_row   = (32'(row) == IMG_H - 1);
        last_col   = (32'(col) == IMG_W - 1);
        diff       = (In_Arrary >= prev) ? (In_Arrary - prev) : (prev - In_Arrary);
        // Sign bit of (diff - THRESH) flags a sub-threshold gradient.
        tdiff      = {2'b00, diff} - 10'(THRESH);
        e          = (line_start || !prev_vld || tdiff[9]) ? 8'd0 : diff;
        proc       = !modeBuffer && enb && !full && !resetBuff;
        we         = proc && !hold;
        wa         = colmajor ? (AW'(col) * AW'(IMG_H) + AW'(row))
                              : (AW'(row) * AW'(IMG_W) + AW'(col));
    end

    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= e;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Edges    <= 8'd0;
            complete <= 1'b0;
            col      <= '0;
            row      <= '0;
            ra       <= '0;
            prev     <= 8'd0;
            prev_vld <= 1'b0;
            full     <= 1'b0;
            rdone    <= 1'b0;
        end else if (resetBuff) begin
            Edges    <= 8'd0;
            complete <= 1'b0;
            col      <= '0;
            row      <= '0;
            ra       <= '0;
            prev_vld <= 1'b0;
            full     <= 1'b0;
            rdone    <= 1'b0;
        end else if (!modeBuffer) begin
            ra       <= '0;
            rdone    <= 1'b0;
            complete <= 1'b0;
            if (proc) begin
                Edges    <= e;
                prev     <= In_Arrary;
                prev_vld <= 1'b1;
                if (!hold) begin
                    // Both scan orders finish at the bottom-right pixel.
                    if (last_row && last_col) begin
                        full <= 1'b1;
                    end else if (colmajor) begin
                        if (last_row) begin
                            row <= '0;
                            col <= col + 1'b1;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end else begin
                        if (last_col) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
            end
        end else begin
            if (rdone)
                complete <= 1'b1;
            if (enb && !rdone) begin
                Edges <= mem[ra];
                if (32'(ra) == N - 1)
                    rdone <= 1'b1;
                else
                    ra <= ra + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_edge_detection.sv
// Directed bench for edge_detection: vector table for gradient/line/threshold/hold cases,
// plus hand-written frame sequences for ramp, transpose, overflow and readout timing.
module tb_edge_detection;
    localparam int N = 256;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] modeCounter;
    logic       modeBuffer;
    logic       resetBuff;
    logic       enb;
    logic [7:0] In_Arrary;
    logic [7:0] Edges;
    logic [7:0] Edges_t;
    logic       complete;
    logic       complete_t;

    always #5 clk = ~clk;

    edge_detection #(.IMG_W(16), .IMG_H(16), .THRESH(0)) dut (
        .clk(clk), .reset(reset), .modeCounter(modeCounter), .modeBuffer(modeBuffer),
        .resetBuff(resetBuff), .enb(enb), .In_Arrary(In_Arrary),
        .Edges(Edges), .complete(complete)
    );

    edge_detection #(.IMG_W(16), .IMG_H(16), .THRESH(20)) dut_t (
        .clk(clk), .reset(reset), .modeCounter(modeCounter), .modeBuffer(modeBuffer),
        .resetBuff(resetBuff), .enb(enb), .In_Arrary(In_Arrary),
        .Edges(Edges_t), .complete(complete_t)
    );

    typedef struct {
        logic       rb;
        logic       en;
        logic [2:0] mc;
        logic [7:0] pix;
        logic [7:0] exp_e;
        logic [7:0] exp_t;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_mem   [N];
    logic [7:0] exp_mem_t [N];
    int         nvec = 0;
    int         nerr = 0;

    function automatic vec_t mk(input logic rb, input logic en, input logic [2:0] mc,
                                input logic [7:0] pix, input logic [7:0] ee, input logic [7:0] et);
        vec_t v;
        v.rb = rb; v.en = en; v.mc = mc; v.pix = pix; v.exp_e = ee; v.exp_t = et;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] p, input logic [2:0] mc);
        modeBuffer  = 1'b0;
        enb         = 1'b1;
        resetBuff   = 1'b0;
        modeCounter = mc;
        In_Arrary   = p;
        tick();
    endtask

    task automatic clear_buf;
        modeBuffer = 1'b0;
        enb        = 1'b1;
        resetBuff  = 1'b1;
        tick();
        resetBuff  = 1'b0;
    endtask

    task automatic readout(input string name, input logic check_t);
        int idx;
        modeBuffer = 1'b1;
        enb        = 1'b1;
        resetBuff  = 1'b0;
        for (int k = 1; k <= N + 2; k++) begin
            tick();
            idx = (k <= N) ? k - 1 : N - 1;
            chk(name, k, Edges, exp_mem[idx]);
            if (check_t)
                chk({name, "_t"}, k, Edges_t, exp_mem_t[idx]);
            chk({name, "_cplt"}, k, {7'd0, complete}, {7'd0, (k > N)});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs
        reset       = 1'b0;
        modeCounter = 3'b001;
        modeBuffer  = 1'b0;
        resetBuff   = 1'b0;
        enb         = 1'b0;
        In_Arrary   = 8'd0;
        for (int i = 0; i < 3; i++) begin
            modeCounter = 3'($urandom);
            modeBuffer  = 1'($urandom);
            resetBuff   = 1'($urandom);
            enb         = 1'($urandom);
            In_Arrary   = 8'($urandom);
            tick();
            chk("rst_edges", i, Edges, 8'd0);
            chk("rst_cplt", i, {7'd0, complete}, 8'd0);
            chk("rst_edges_t", i, Edges_t, 8'd0);
        end
        reset      = 1'b1;
        modeBuffer = 1'b1;
        enb        = 1'b1;
        resetBuff  = 1'b0;
        for (int k = 1; k <= N + 2; k++) begin
            tick();
            chk("init_cplt", k, {7'd0, complete}, {7'd0, (k > N)});
        end

        // Leaving read mode clears complete; then an async reset mid-frame
        wr(8'd5, 3'b001);
        chk("mode_clr_cplt", 0, {7'd0, complete}, 8'd0);
        wr(8'd60, 3'b001);
        chk("pre_abort", 0, Edges, 8'd55);
        #2;
        reset = 1'b0;
        #1;
        chk("async_abort", 0, Edges, 8'd0);
        reset = 1'b1;

        // Line boundary, abs value, enb hold, hold counter mode
        tbl.push_back(mk(1, 1, 3'b001, 8'd0,   8'd0,   8'd0));
        tbl.push_back(mk(0, 1, 3'b001, 8'd200, 8'd0,   8'd0));
        tbl.push_back(mk(0, 1, 3'b001, 8'd50,  8'd150, 8'd150));
        tbl.push_back(mk(0, 1, 3'b001, 8'd50,  8'd0,   8'd0));
        tbl.push_back(mk(0, 1, 3'b001, 8'd255, 8'd205, 8'd205));
        for (int i = 0; i < 2; i++)
            tbl.push_back(mk(0, 0, 3'b001, 8'd9, 8'd205, 8'd205));
        for (int i = 0; i < 12; i++)
            tbl.push_back(mk(0, 1, 3'b001, 8'd255, 8'd0, 8'd0));
        tbl.push_back(mk(0, 1, 3'b001, 8'd0,   8'd0,   8'd0));
        tbl.push_back(mk(0, 1, 3'b001, 8'd7,   8'd7,   8'd0));
        tbl.push_back(mk(0, 1, 3'b000, 8'd30,  8'd23,  8'd23));
        tbl.push_back(mk(0, 1, 3'b000, 8'd30,  8'd0,   8'd0));
        // Threshold and enb freeze, frame continues afterwards
        tbl.push_back(mk(1, 1, 3'b001, 8'd0,   8'd0,   8'd0));
        tbl.push_back(mk(0, 1, 3'b001, 8'd100, 8'd0,   8'd0));
        tbl.push_back(mk(0, 1, 3'b001, 8'd110, 8'd10,  8'd0));
        tbl.push_back(mk(0, 1, 3'b001, 8'd140, 8'd30,  8'd30));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 0, 3'b001, 8'd7, 8'd30, 8'd30));
        tbl.push_back(mk(0, 1, 3'b001, 8'd150, 8'd10,  8'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            modeBuffer  = 1'b0;
            resetBuff   = tbl[i].rb;
            enb         = tbl[i].en;
            modeCounter = tbl[i].mc;
            In_Arrary   = tbl[i].pix;
            tick();
            chk("tbl", i, Edges, tbl[i].exp_e);
            chk("tbl_t", i, Edges_t, tbl[i].exp_t);
        end

        for (int i = 4; i < N; i++)
            wr(8'd150, 3'b001);
        for (int a = 0; a < N; a++) begin
            exp_mem[a]   = 8'd0;
            exp_mem_t[a] = 8'd0;
        end
        exp_mem[1]   = 8'd10;
        exp_mem[2]   = 8'd30;
        exp_mem[3]   = 8'd10;
        exp_mem_t[2] = 8'd30;
        readout("thr_rd", 1'b1);

        // Row-major ramp with 44 overflow pixels
        clear_buf();
        for (int i = 0; i < 300; i++) begin
            wr((i < N) ? 8'((i % 16) * 10) : 8'd99, 3'b001);
            chk("ramp_wr", i, Edges, (i < N && i % 16 == 0) ? 8'd0 : 8'd10);
        end
        for (int a = 0; a < N; a++) begin
            exp_mem[a]   = (a % 16 == 0) ? 8'd0 : 8'd10;
            exp_mem_t[a] = 8'd0;
        end
        readout("ramp_rd", 1'b1);

        // resetBuff in read mode rewinds the readout
        resetBuff = 1'b1;
        tick();
        chk("rb_cplt", 0, {7'd0, complete}, 8'd0);
        chk("rb_edges", 0, Edges, 8'd0);
        readout("ramp_rd2", 1'b0);

        // Column-major scan of image pixel = col*10 + row
        clear_buf();
        for (int i = 0; i < N; i++) begin
            wr(8'((i / 16) * 10 + (i % 16)), 3'b010);
            chk("tr_wr", i, Edges, (i % 16 == 0) ? 8'd0 : 8'd1);
        end
        for (int a = 0; a < N; a++) begin
            exp_mem[a]   = (a % 16 == 0) ? 8'd0 : 8'd1;
            exp_mem_t[a] = 8'd0;
        end
        readout("tr_rd", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
